// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the 8N1 UART slice: the state encoding used by both
// the transmit and receive state machines, the number of data bits per frame
// and the logic level of an idle serial line.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_engine.sv
// uart_rx_engine
// Receive half of the UART: a two-flop synchroniser on the serial input
// followed by the receive state machine, which samples each bit at its
// centre and strobes out a byte when a frame ends with a valid stop bit.
//
// Ports:
//   CLK       system clock, rising edge
//   RST       synchronous active-high reset
//   RX        asynchronous serial input, idles high
//   o_RX_DV   one-cycle pulse when o_RX_Byte has been updated
//   o_RX_Byte last byte received with a good stop bit
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  logic          rx_meta;
  logic          rx_sync;
  uart_state_e   rx_state;
  logic [CW-1:0] rx_count;
  logic [2:0]    rx_index;
  logic [7:0]    rx_shift;

  // Synchroniser flops reset to the idle level so that leaving reset never
  // looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= LINE_IDLE;
      rx_sync <= LINE_IDLE;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  // The START state waits half a bit so every later sample, taken one full
  // bit period apart, lands in the middle of its bit cell. A line that is
  // high again at mid-start was only a glitch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state  <= IDLE;
      rx_count  <= '0;
      rx_index  <= '0;
      rx_shift  <= '0;
      o_RX_DV   <= 1'b0;
      o_RX_Byte <= '0;
    end else begin
      o_RX_DV <= 1'b0;
      case (rx_state)
        IDLE: begin
          rx_count <= '0;
          rx_index <= '0;
          if (rx_sync == 1'b0) rx_state <= START;
        end
        START: begin
          if (rx_count == HALF_BIT) begin
            rx_count <= '0;
            rx_state <= (rx_sync == 1'b0) ? DATA : IDLE;
          end else begin
            rx_count <= rx_count + 1'b1;
          end
        end
        DATA: begin
          if (rx_count == BIT_LAST) begin
            rx_count           <= '0;
            rx_shift[rx_index] <= rx_sync;
            if (rx_index == LAST_IDX) begin
              rx_index <= '0;
              rx_state <= STOP;
            end else begin
              rx_index <= rx_index + 1'b1;
            end
          end else begin
            rx_count <= rx_count + 1'b1;
          end
        end
        STOP: begin
          if (rx_count == BIT_LAST) begin
            rx_count <= '0;
            rx_state <= CLEANUP;
            // A low stop bit is a framing error; the byte is dropped.
            if (rx_sync == LINE_IDLE) begin
              o_RX_Byte <= rx_shift;
              o_RX_DV   <= 1'b1;
            end
          end else begin
            rx_count <= rx_count + 1'b1;
          end
        end
        CLEANUP: rx_state <= IDLE;
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_txrx.sv
// uart_txrx
// Single-clock 8N1 UART with independent transmitter and receiver. The
// transmit state machine lives here; reception is handled by uart_rx_engine.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   i_TX_DV      one-cycle request to send i_TX_Byte (honoured only in IDLE)
//   i_TX_Byte    byte to send, captured when the request is accepted
//   TX           serial output, idles high
//   o_TX_Active  high for the whole 10-bit frame
//   o_TX_Done    one-cycle pulse in the last cycle of the stop bit
//   RX           asynchronous serial input, idles high
//   o_RX_DV      one-cycle pulse when o_RX_Byte has been updated
//   o_RX_Byte    last byte received with a good stop bit
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       TX,
  output logic       o_TX_Active,
  output logic       o_TX_Done,
  input  logic       RX,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_AT  = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_e   tx_state;
  logic [CW-1:0] tx_count;
  logic [2:0]    tx_index;
  logic [7:0]    tx_data;

  // All outputs are registered, so each state loads the line level for the
  // following cycle: the start bit is driven from the accepting IDLE cycle
  // and each data bit from the last cycle of the bit before it. o_TX_Done is
  // raised one cycle early so its pulse coincides with the final stop cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state    <= IDLE;
      tx_count    <= '0;
      tx_index    <= '0;
      tx_data     <= '0;
      TX          <= LINE_IDLE;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          TX        <= LINE_IDLE;
          o_TX_Done <= 1'b0;
          tx_count  <= '0;
          tx_index  <= '0;
          if (i_TX_DV) begin
            tx_data     <= i_TX_Byte;
            TX          <= 1'b0;
            o_TX_Active <= 1'b1;
            tx_state    <= START;
          end
        end
        START: begin
          if (tx_count == BIT_LAST) begin
            tx_count <= '0;
            TX       <= tx_data[0];
            tx_state <= DATA;
          end else begin
            tx_count <= tx_count + 1'b1;
          end
        end
        DATA: begin
          if (tx_count == BIT_LAST) begin
            tx_count <= '0;
            if (tx_index == LAST_IDX) begin
              tx_index <= '0;
              TX       <= LINE_IDLE;
              tx_state <= STOP;
            end else begin
              tx_index <= tx_index + 1'b1;
              TX       <= tx_data[tx_index + 3'd1];
            end
          end else begin
            tx_count <= tx_count + 1'b1;
          end
        end
        STOP: begin
          if (tx_count == BIT_LAST) begin
            tx_count    <= '0;
            o_TX_Done   <= 1'b0;
            o_TX_Active <= 1'b0;
            tx_state    <= CLEANUP;
          end else begin
            tx_count <= tx_count + 1'b1;
            if (tx_count == DONE_AT) o_TX_Done <= 1'b1;
          end
        end
        CLEANUP: begin
          // Guaranteed idle gap; a request arriving now is not taken.
          TX       <= LINE_IDLE;
          tx_state <= IDLE;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  uart_rx_engine #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .CLK      (CLK),
    .RST      (RST),
    .RX       (RX),
    .o_RX_DV  (o_RX_DV),
    .o_RX_Byte(o_RX_Byte)
  );

endmodule

// File: tb/tb_uart_txrx.sv
// tb_uart_txrx
// Self-checking bench for uart_txrx at 217 clocks per bit with a 40 ns clock.
// Received bytes are checked by a scoreboard: every byte expected on the RX
// side is queued when its frame is launched and a monitor pops and compares
// on each o_RX_DV pulse.
module tb_uart_txrx;

  localparam int CPB = 217;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       i_TX_DV = 1'b0;
  logic [7:0] i_TX_Byte = 8'h00;
  logic       TX;
  logic       o_TX_Active;
  logic       o_TX_Done;
  logic       RX;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;

  logic       loopEn = 1'b1;
  logic       rxManual = 1'b1;

  int         checks = 0;
  int         failures = 0;
  int         doneCount = 0;
  logic [7:0] expQ[$];
  logic [7:0] expByte;

  always #20 CLK = ~CLK;

  assign RX = loopEn ? (o_TX_Active ? TX : 1'b1) : rxManual;

  uart_txrx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .i_TX_DV    (i_TX_DV),
    .i_TX_Byte  (i_TX_Byte),
    .TX         (TX),
    .o_TX_Active(o_TX_Active),
    .o_TX_Done  (o_TX_Done),
    .RX         (RX),
    .o_RX_DV    (o_RX_DV),
    .o_RX_Byte  (o_RX_Byte)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Strobe i_TX_DV for one cycle; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [7:0] b, input bit expectRx);
    @(negedge CLK);
    i_TX_DV   = 1'b1;
    i_TX_Byte = b;
    if (expectRx) expQ.push_back(b);
    @(negedge CLK);
    i_TX_DV = 1'b0;
  endtask

  task automatic sendRxFrame(input logic [7:0] b, input logic stopVal,
                             input int stopLen);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rxManual = bits[i];
      repeat (CPB) @(negedge CLK);
    end
    rxManual = stopVal;
    repeat (stopLen) @(negedge CLK);
    rxManual = 1'b1;
  endtask

  task automatic waitDone(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!o_TX_Done && n < limit);
    checkOutput("tx_done_seen", {15'd0, o_TX_Done}, 16'd1);
  endtask

  task automatic waitQueueEmpty(input int limit);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < limit) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("rx_queue_drained", 16'(expQ.size()), 16'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tx"},        {15'd0, TX},          16'd1);
    checkOutput({tag, "_tx_active"}, {15'd0, o_TX_Active}, 16'd0);
    checkOutput({tag, "_tx_done"},   {15'd0, o_TX_Done},   16'd0);
    checkOutput({tag, "_rx_dv"},     {15'd0, o_RX_DV},     16'd0);
    checkOutput({tag, "_rx_byte"},   {8'd0, o_RX_Byte},    16'h0000);
  endtask

  // Scoreboard monitor: every o_RX_DV pulse must match the oldest queued byte.
  always @(negedge CLK) begin
    if (o_TX_Done) doneCount++;
    if (o_RX_DV) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rx_dv: got byte %0h, expected no pulse", o_RX_Byte);
      end else begin
        expByte = expQ.pop_front();
        checkOutput("rx_byte", {8'd0, o_RX_Byte}, {8'd0, expByte});
      end
    end
  end

  // Bound on total run time.
  initial begin
    repeat (60000) @(posedge CLK);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneBase;
    int activeCycles;
    int doneAt;
    logic [9:0] frame;

    // Reset state
    repeat (3) @(negedge CLK);
    checkResetOutputs("reset");
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // Loopback 8'h3A with bit timing relative to the accepting edge
    $display("[TB] loopback 3A with bit timing");
    doneBase     = doneCount;
    activeCycles = 0;
    doneAt       = -1;
    frame        = {1'b1, 8'h3A, 1'b0};
    applyStimulus(8'h3A, 1'b1);
    for (int k = 0; k <= 2172; k++) begin
      if (k > 0) @(negedge CLK);
      if (o_TX_Active) activeCycles++;
      if (o_TX_Done && doneAt < 0) doneAt = k;
      if (k == 0)   checkOutput("start_first_cycle", {15'd0, TX}, 16'd0);
      if (k == 216) checkOutput("start_last_cycle",  {15'd0, TX}, 16'd0);
      if (k < 10 * CPB && (k % CPB) == CPB / 2)
        checkOutput($sformatf("tx_bit%0d", k / CPB), {15'd0, TX},
                    {15'd0, frame[k / CPB]});
    end
    checkOutput("active_cycles", 16'(activeCycles), 16'd2170);
    checkOutput("done_position", 16'(doneAt), 16'd2169);
    waitQueueEmpty(100);
    checkOutput("done_pulses_3a", 16'(doneCount - doneBase), 16'd1);

    // Back-to-back 00 then FF, with a mid-frame request that must be ignored
    $display("[TB] back-to-back 00 / FF");
    doneBase = doneCount;
    applyStimulus(8'h00, 1'b1);
    repeat (1000) @(negedge CLK);
    i_TX_DV   = 1'b1;
    i_TX_Byte = 8'h77;
    @(negedge CLK);
    i_TX_DV = 1'b0;
    waitDone(2400);
    @(negedge CLK);
    // CLEANUP cycle: raise the request here and hold it into the IDLE cycle
    i_TX_DV   = 1'b1;
    i_TX_Byte = 8'hFF;
    expQ.push_back(8'hFF);
    @(negedge CLK);
    checkOutput("cleanup_request_ignored", {15'd0, o_TX_Active}, 16'd0);
    @(negedge CLK);
    checkOutput("idle_request_accepted", {15'd0, o_TX_Active}, 16'd1);
    i_TX_DV = 1'b0;
    waitDone(2400);
    waitQueueEmpty(300);
    repeat (20) @(negedge CLK);
    checkOutput("done_pulses_b2b", 16'(doneCount - doneBase), 16'd2);

    // RX glitch followed by a valid A5 frame
    $display("[TB] rx glitch then A5");
    loopEn   = 1'b0;
    rxManual = 1'b0;
    repeat (50) @(negedge CLK);
    rxManual = 1'b1;
    repeat (400) @(negedge CLK);
    checkOutput("glitch_no_byte", 16'(expQ.size()), 16'd0);
    expQ.push_back(8'hA5);
    sendRxFrame(8'hA5, 1'b1, CPB);
    waitQueueEmpty(600);
    repeat (50) @(negedge CLK);

    // Framing error on 8'h55: no pulse and the previous byte is kept
    $display("[TB] framing error 55");
    sendRxFrame(8'h55, 1'b0, 130);
    repeat (400) @(negedge CLK);
    checkOutput("framing_byte_held", {8'd0, o_RX_Byte}, 16'h00A5);

    // Reset mid-DATA while sending C3, then a clean 3C
    $display("[TB] reset mid-frame");
    loopEn = 1'b1;
    applyStimulus(8'hC3, 1'b0);
    repeat (3 * CPB + 50) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checkResetOutputs("midreset");
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    doneBase = doneCount;
    applyStimulus(8'h3C, 1'b1);
    waitDone(2400);
    waitQueueEmpty(300);
    repeat (20) @(negedge CLK);
    checkOutput("done_pulses_3c", 16'(doneCount - doneBase), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
- Single-clock 8N1 UART block with an independent transmitter and receiver.
- TX serialises a byte on a one-cycle strobe. RX deserialises the line and strobes the received byte.
- Used as the serial endpoint next to logic that produces and consumes bytes; the TX pin may be looped back to RX for self-test.
- Baud rate is fixed by a clocks-per-bit parameter, e.g. 25 MHz / 115200 = 217.

Parameters:
- CLKS_PER_BIT, 217, CLK cycles per serial bit; must be at least 4. Counter width is $clog2(CLKS_PER_BIT)+1.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- i_TX_DV  in  1  one-cycle strobe requesting transmission of i_TX_Byte.
- i_TX_Byte  in  8  byte to send; sampled only in the cycle i_TX_DV is accepted.
- TX  out  1  serial output; idles high.
- o_TX_Active  out  1  high while a frame is being sent.
- o_TX_Done  out  1  one-cycle pulse at the end of the stop bit.
- RX  in  1  asynchronous serial input; idles high.
- o_RX_DV  out  1  one-cycle pulse when a valid byte is available.
- o_RX_Byte  out  8  last valid received byte; holds until the next valid frame.

Behaviour:
- Reset applied in any state:
  - returns both FSMs to IDLE and zeroes all counters;
  - TX=1, o_TX_Active=0, o_TX_Done=0, o_RX_DV=0, o_RX_Byte=8'h00;
  - RX synchroniser flops preset to 1.
  - A frame in progress is aborted, and TX returns high on the next cycle.
- Frame format: start bit 0, then 8 data bits LSB first, then 1 stop bit of value 1. No parity.
- TX FSM: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
  - IDLE: TX=1, o_TX_Active=0. If i_TX_DV=1, latch i_TX_Byte and go to START. On the following cycle TX=0 and o_TX_Active=1.
  - START, DATA (each of the 8 bits) and STOP each last exactly CLKS_PER_BIT cycles.
  - A full frame is 10*CLKS_PER_BIT cycles of o_TX_Active=1.
  - In the last cycle of STOP, o_TX_Done pulses for 1 cycle and o_TX_Active drops on the next cycle.
  - CLEANUP lasts 1 cycle with TX=1, so at least 1 idle cycle separates frames.
  - i_TX_DV outside IDLE is ignored; no queueing.
  - i_TX_DV asserted in the CLEANUP cycle is ignored; it is accepted on the first IDLE cycle.
- RX path: RX passes through a 2-flop synchroniser; all decisions use the synchronised value.
- RX FSM: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
  - IDLE: wait for the synchronised line to read 0.
  - START: count to (CLKS_PER_BIT-1)/2 (integer division) and resample at mid-bit.
    - If the line is 0, clear the counter and go to DATA.
    - If it is 1, treat it as a glitch and return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles sample one bit into index 0..7 (LSB first). After bit 7 go to STOP.
  - STOP: after CLKS_PER_BIT cycles sample the stop bit.
    - If it is 1, load o_RX_Byte and pulse o_RX_DV for exactly 1 cycle, coincident with the new o_RX_Byte.
    - If it is 0 (framing error), discard the byte: no o_RX_DV, o_RX_Byte unchanged.
  - CLEANUP: 1 cycle, then IDLE.
- End-of-frame latency: o_RX_DV rises about 9.5*CLKS_PER_BIT + 3 cycles after the RX start-bit falling edge.
- TX and RX operate fully independently; simultaneous transmit and receive is supported.

Decomposition:
- Package uart_pkg holds:
  - the TX/RX state enum (IDLE, START, DATA, STOP, CLEANUP);
  - the constants DATA_BITS=8 and LINE_IDLE=1'b1.
- One natural sub-module, uart_rx_engine: synchroniser plus RX FSM. The TX FSM stays inline in uart_txrx.

Test Plan:
- Loopback with RX tied to (o_TX_Active ? TX : 1), CLKS_PER_BIT=217, 40 ns clock: strobe i_TX_DV with i_TX_Byte=8'h3A for one cycle -> one o_RX_DV pulse with o_RX_Byte=8'h3A, and o_TX_Done pulses exactly once.
- Bit timing for 8'h3A: TX low exactly 217 cycles after acceptance, then 0,1,0,1,1,1,0,0 with 217 cycles each, then a 217-cycle stop bit of 1 -> o_TX_Active high for 2170 cycles.
- Back-to-back 8'h00 then 8'hFF, each sent on the first IDLE after o_TX_Done, plus a second i_TX_DV mid-frame -> exactly two o_RX_DV pulses with 8'h00 and 8'hFF; the mid-frame request is ignored.
- RX glitch: drive RX low for 50 cycles, then high -> no o_RX_DV and RX FSM back in IDLE; a following valid 8'hA5 frame is received as 8'hA5.
- Framing error: drive a frame for 8'h55 with stop bit 0 -> no o_RX_DV and o_RX_Byte keeps its previous value.
- Reset: assert RST for 1 cycle mid-DATA during transmission of 8'hC3 -> next cycle TX=1, o_TX_Active=0, o_TX_Done=0, o_RX_DV=0, o_RX_Byte=8'h00; a new send of 8'h3C completes correctly.
